// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the 2-read/1-write register file.
// Imported by the sweep controller and the storage top.
package regfile_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    IDLE,
    SWEEP
  } sweep_state_e;

endpackage

// File: rtl/regfile_sweep_ctrl.sv
// Clear-sweep sequencer: on init, walks entries 0..DEPTH-1,
// one per cycle, then returns to idle.
module regfile_sweep_ctrl
  import regfile_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     init,
  output logic                     busy,
  output logic [$clog2(DEPTH)-1:0] clr_addr,
  output logic                     clr_en
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  sweep_state_e      state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // init is ignored once sweeping; counter wraps to 0 on exit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (init) begin
          state_d = SWEEP;
          cnt_d   = '0;
        end
      end
      SWEEP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q == SWEEP);
  assign clr_en   = busy;
  assign clr_addr = cnt_q;

endmodule

// File: rtl/register_file_2r1w.sv
// Register file, two registered read ports, one write port,
// write-through bypass and a one-entry-per-cycle clear sweep.
module register_file_2r1w
  import regfile_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int ZERO_REG = 0
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     write,
  input  logic [$clog2(DEPTH)-1:0] wr_address,
  input  logic [WIDTH-1:0]         in,
  input  logic [$clog2(DEPTH)-1:0] r_address_a,
  input  logic [$clog2(DEPTH)-1:0] r_address_b,
  input  logic                     init,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [WIDTH-1:0]  out_a_q, out_a_d;
  logic [WIDTH-1:0]  out_b_q, out_b_d;
  logic              wr_drop_q, wr_drop_d;
  logic              busy_w;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_zero;
  logic              wr_ok;

  regfile_sweep_ctrl #(
    .DEPTH(DEPTH)
  ) u_sweep (
    .clk     (clk),
    .clr     (clr),
    .init    (init),
    .busy    (busy_w),
    .clr_addr(clr_addr),
    .clr_en  (clr_en)
  );

  assign wr_zero   = (ZERO_REG != 0) && (wr_address == '0);
  assign wr_ok     = write && !busy_w && !wr_zero;
  assign wr_drop_d = write && busy_w;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    if (wr_ok) begin
      mem_d[wr_address] = in;
    end
    if (clr_en) begin
      mem_d[clr_addr] = '0;
    end
    if (ZERO_REG != 0) begin
      mem_d[0] = '0;
    end
  end

  // read data reflects this cycle's write or clear, not the stale entry
  always_comb begin
    out_a_d = mem_q[r_address_a];
    if ((ZERO_REG != 0) && (r_address_a == '0)) begin
      out_a_d = '0;
    end else if (wr_ok && (r_address_a == wr_address)) begin
      out_a_d = in;
    end else if (clr_en && (r_address_a == clr_addr)) begin
      out_a_d = '0;
    end
  end

  always_comb begin
    out_b_d = mem_q[r_address_b];
    if ((ZERO_REG != 0) && (r_address_b == '0)) begin
      out_b_d = '0;
    end else if (wr_ok && (r_address_b == wr_address)) begin
      out_b_d = in;
    end else if (clr_en && (r_address_b == clr_addr)) begin
      out_b_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      out_a_q   <= '0;
      out_b_q   <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      out_a_q   <= out_a_d;
      out_b_q   <= out_b_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  assign out_a   = out_a_q;
  assign out_b   = out_b_q;
  assign busy    = busy_w;
  assign wr_drop = wr_drop_q;

endmodule
